// File: rtl/mult_pkg.sv
// mult_pkg: shared multiplier command type and pipeline depth
package mult_pkg;
  typedef enum logic [1:0] {CMD_MUL, CMD_MULH, CMD_MULHSU, CMD_MULHU} mult_cmd_t;
  localparam int NB_STAGES_DEF = 3;
  localparam int REG_W = 6;
endpackage

// File: rtl/mult_stage_reg.sv
// mult_stage_reg: one pipeline slot holding valid, destination and command
module mult_stage_reg
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             adv,
  input  logic             flush,
  input  logic [REG_W-1:0] rd_in,
  input  mult_cmd_t        cmd_in,
  output logic             valid,
  output logic [REG_W-1:0] rd,
  output mult_cmd_t        cmd
);
  logic             valid_d, valid_q;
  logic [REG_W-1:0] rd_d, rd_q;
  mult_cmd_t        cmd_d, cmd_q;
  always_comb begin
    valid_d = flush ? 1'b0 : load ? 1'b1 : adv ? 1'b0 : valid_q;
    rd_d    = (load && !flush) ? rd_in : rd_q;
    cmd_d   = (load && !flush) ? cmd_in : cmd_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      cmd_q   <= CMD_MUL;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cmd_q   <= cmd_d;
    end
  end
  assign valid = valid_q;
  assign rd    = rd_q;
  assign cmd   = cmd_q;
endmodule

// File: rtl/mult_pipe_ctrl.sv
// mult_pipe_ctrl: multiplier pipeline control; MULT_PERF_CNT_EN adds issue/stall counters
module mult_pipe_ctrl
  import mult_pkg::*;
#(
  parameter int NB_STAGES = NB_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 DEC2X0_EMPTY_SD,
  input  logic [1:0]           MULT_CMD_SD,
  input  logic [REG_W-1:0]     RADR_SD,
  input  logic [REG_W-1:0]     RADR1_SD,
  input  logic [REG_W-1:0]     RADR2_SD,
  input  logic                 WB_READY_SM,
  input  logic                 FLUSH_SM,
  output logic                 DEC2X0_POP_SX0,
  output logic [NB_STAGES-1:0] STAGE_VALID_SX,
  output logic [NB_STAGES-1:0] STAGE_ADV_SX,
  output logic [REG_W-1:0]     X2_RD_SX2,
  output logic [1:0]           X2_CMD_SX2,
  output logic                 RETIRE_SX2,
  output logic                 MULT_HAZARD_SD,
  output logic                 MULT_BUSY_SX
`ifdef MULT_PERF_CNT_EN
  ,
  output logic [31:0]          PERF_ISSUE_SX,
  output logic [31:0]          PERF_STALL_SX
`endif
);
  logic [NB_STAGES-1:0] valid, adv, load;
  logic [REG_W-1:0]     rd     [NB_STAGES];
  logic [REG_W-1:0]     rd_in  [NB_STAGES];
  mult_cmd_t            cmd    [NB_STAGES];
  mult_cmd_t            cmd_in [NB_STAGES];
  logic                 pop, retire, hazard;
  // A stage advances unless it and every stage above it are full while writeback stalls.
  always_comb begin
    logic blk;
    blk = ~WB_READY_SM;
    adv = '0;
    for (int i = NB_STAGES - 1; i >= 0; i--) begin
      adv[i] = valid[i] & ~blk;
      blk    = blk & valid[i];
    end
  end
  assign pop    = reset_n & ~DEC2X0_EMPTY_SD & (~valid[0] | adv[0]) & ~FLUSH_SM;
  assign retire = valid[NB_STAGES-1] & WB_READY_SM & ~FLUSH_SM;
  always_comb begin
    load[0]   = pop;
    rd_in[0]  = RADR_SD;
    cmd_in[0] = mult_cmd_t'(MULT_CMD_SD);
    for (int i = 1; i < NB_STAGES; i++) begin
      load[i]   = adv[i-1];
      rd_in[i]  = rd[i-1];
      cmd_in[i] = cmd[i-1];
    end
  end
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NB_STAGES; i++)
      hazard = hazard | (valid[i] & ~((i == NB_STAGES - 1) & retire) &
               (((RADR1_SD != '0) & (RADR1_SD == rd[i])) | ((RADR2_SD != '0) & (RADR2_SD == rd[i]))));
  end
  for (genvar s = 0; s < NB_STAGES; s++) begin : g_stage
    mult_stage_reg u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (load[s]),
      .adv    (adv[s]),
      .flush  (FLUSH_SM),
      .rd_in  (rd_in[s]),
      .cmd_in (cmd_in[s]),
      .valid  (valid[s]),
      .rd     (rd[s]),
      .cmd    (cmd[s])
    );
  end
  assign DEC2X0_POP_SX0 = pop;
  assign STAGE_VALID_SX = valid;
  assign STAGE_ADV_SX   = adv;
  assign X2_RD_SX2      = rd[NB_STAGES-1];
  assign X2_CMD_SX2     = cmd[NB_STAGES-1];
  assign RETIRE_SX2     = retire;
  assign MULT_HAZARD_SD = hazard;
  assign MULT_BUSY_SX   = |valid;
`ifdef MULT_PERF_CNT_EN
  logic [31:0] issue_d, issue_q, stall_d, stall_q;
  always_comb begin
    issue_d = issue_q + {31'd0, pop};
    stall_d = stall_q + {31'd0, valid[NB_STAGES-1] & ~WB_READY_SM};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      issue_q <= issue_d;
      stall_q <= stall_d;
    end
  end
  assign PERF_ISSUE_SX = issue_q;
  assign PERF_STALL_SX = stall_q;
`endif
endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// tb_mult_pipe_ctrl: scoreboard bench with a slot-level reference model of the pipeline
module tb_mult_pipe_ctrl;
  localparam int N = 3;
  typedef struct packed {logic [5:0] rd; logic [1:0] cmd;} op_t;
  logic clk = 1'b0, reset_n = 1'b0, empty = 1'b1, ready = 1'b0, flush = 1'b0;
  logic [1:0] cmd = '0;
  logic [5:0] rd = '0, s1 = '0, s2 = '0;
  logic pop_o, retire_o, haz_o, busy_o;
  logic [N-1:0] valid_o, adv_o;
  logic [5:0] x2rd_o;
  logic [1:0] x2cmd_o;
`ifdef MULT_PERF_CNT_EN
  logic [31:0] perf_issue, perf_stall;
`endif
  mult_pipe_ctrl dut (
    .clk(clk), .reset_n(reset_n), .DEC2X0_EMPTY_SD(empty), .MULT_CMD_SD(cmd),
    .RADR_SD(rd), .RADR1_SD(s1), .RADR2_SD(s2), .WB_READY_SM(ready), .FLUSH_SM(flush),
    .DEC2X0_POP_SX0(pop_o), .STAGE_VALID_SX(valid_o), .STAGE_ADV_SX(adv_o),
    .X2_RD_SX2(x2rd_o), .X2_CMD_SX2(x2cmd_o), .RETIRE_SX2(retire_o),
    .MULT_HAZARD_SD(haz_o), .MULT_BUSY_SX(busy_o)
`ifdef MULT_PERF_CNT_EN
    , .PERF_ISSUE_SX(perf_issue), .PERF_STALL_SX(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0, issue_m = 0, stall_m = 0;
  logic mv [N];
  logic [5:0] mr [N];
  logic [1:0] mc [N];
  op_t sb [$];
  op_t exp_op;
  int retire_cyc [$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; mr[i] = '0; mc[i] = '0;
    end
    sb.delete();
    issue_m = 0; stall_m = 0;
  endtask
  // One clock: drive inputs, compare combinational outputs with the model, then advance the model.
  task automatic step(input logic e, input logic [1:0] c, input logic [5:0] r,
                      input logic rdy, input logic fl, input logic [5:0] a, input logic [5:0] b);
    logic mov [N];
    logic ep, er, eh;
    logic [N-1:0] ev, ea;
    @(posedge clk); #1;
    empty = e; cmd = c; rd = r; ready = rdy; flush = fl; s1 = a; s2 = b;
    cyc++;
    #1;
    for (int i = N - 1; i >= 0; i--) begin
      if (i == N - 1) mov[i] = mv[i] && rdy;
      else mov[i] = mv[i] && (!mv[i+1] || mov[i+1]);
    end
    er = mv[N-1] && rdy && !fl;
    ep = !e && (!mv[0] || mov[0]) && !fl;
    eh = 1'b0;
    for (int i = 0; i < N; i++) begin
      ev[i] = mv[i]; ea[i] = mov[i];
      if (mv[i] && !(i == N - 1 && er) && ((a != 0 && a == mr[i]) || (b != 0 && b == mr[i]))) eh = 1'b1;
    end
    check("pop", pop_o, ep);
    check("retire", retire_o, er);
    check("hazard", haz_o, eh);
    check("valid", valid_o, ev);
    check("adv", adv_o, ea);
    check("busy", busy_o, |ev);
    if (busy_o) busy_cnt++;
    if (mv[N-1] && !rdy) stall_m++;
    if (ep) begin issue_m++; sb.push_back({r, c}); end
    if (fl) begin
      sb.delete();
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (mov[i]) begin
          if (i < N - 1) begin mv[i+1] = 1'b1; mr[i+1] = mr[i]; mc[i+1] = mc[i]; end
          mv[i] = 1'b0;
        end
      if (ep) begin mv[0] = 1'b1; mr[0] = r; mc[0] = c; end
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; empty = 1'b0; ready = 1'b1; s1 = 6'd1; s2 = 6'd2;
    #1;
    check("rst_pop", pop_o, 0);
    check("rst_retire", retire_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_adv", adv_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_hazard", haz_o, 0);
    check("rst_x2", {x2rd_o, x2cmd_o}, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 empty = 1'b1; reset_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (reset_n && retire_o) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL retire_unexpected: got rd %0d with no op expected (cycle %0d)", x2rd_o, cyc);
      end else begin
        exp_op = sb.pop_front();
        check("retire_rd", x2rd_o, exp_op.rd);
        check("retire_cmd", x2cmd_o, exp_op.cmd);
        retire_cyc.push_back(cyc);
      end
    end
  end
  initial begin
    int base;
    clear_model();
    do_reset();
    // back-to-back issue, retires three cycles after each pop
    retire_cyc.delete();
    base = cyc + 1;
    for (int j = 1; j <= 4; j++) step(1'b0, 2'(j), 6'(j), 1'b1, 1'b0, 0, 0);
    repeat (4) step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    check("b2b_count", retire_cyc.size(), 4);
    for (int j = 0; j < 4 && j < retire_cyc.size(); j++) check("b2b_latency", retire_cyc[j], base + 3 + j);
    // backpressure
    for (int j = 1; j <= 3; j++) step(1'b0, 2'd1, 6'(10 + j), 1'b1, 1'b0, 0, 0);
    repeat (5) step(1'b0, 2'd2, 6'd20, 1'b0, 1'b0, 0, 0);
    check("bp_hold", valid_o, 3'b111);
    repeat (6) step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    // hazard on X1, and rd 0 never hazards
    do_reset();
    step(1'b0, 2'd0, 6'd5, 1'b1, 1'b0, 0, 0);
    step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    step(1'b1, 0, 0, 1'b1, 1'b0, 6'd5, 0);
    check("haz_x1", haz_o, 1);
    repeat (2) step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 2'd3, 6'd0, 1'b1, 1'b0, 0, 0);
    step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    check("haz_r0", haz_o, 0);
    repeat (2) step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    // flush with three valid and a pending pop
    for (int j = 1; j <= 3; j++) step(1'b0, 2'd0, 6'(30 + j), 1'b0, 1'b0, 0, 0);
    step(1'b0, 2'd1, 6'd40, 1'b1, 1'b1, 0, 0);
    check("flush_pop", pop_o, 0);
    check("flush_retire", retire_o, 0);
    step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    check("flush_clear", valid_o, 0);
    // reset with X2 valid
    for (int j = 1; j <= 3; j++) step(1'b0, 2'd2, 6'(50 + j), 1'b0, 1'b0, 0, 0);
    do_reset();
    step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    check("post_rst_retire", retire_o, 0);
    // single op then empty: busy for exactly NB_STAGES cycles
    busy_cnt = 0;
    step(1'b0, 2'd3, 6'd7, 1'b1, 1'b0, 0, 0);
    repeat (6) step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    check("bubble_busy", busy_cnt, N);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    end
    repeat (8) step(1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    check("drain_empty", sb.size(), 0);
`ifdef MULT_PERF_CNT_EN
    check("perf_issue", perf_issue, issue_m);
    check("perf_stall", perf_stall, stall_m);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_pipe_ctrl.md
MULT_PIPE_CTRL -- requirements
Module: mult_pipe_ctrl

Interface
REQ-001 SHALL have parameter NB_STAGES, default 3, number of multiplier pipeline stages (X0, X1, X2).
REQ-002 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port DEC2X0_EMPTY_SD, input, 1, decode-to-X0 FIFO empty; low means a request is available.
REQ-005 SHALL have port MULT_CMD_SD, input, 2, command: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have port RADR_SD, input, 6, destination register of the request.
REQ-007 SHALL have port RADR1_SD / RADR2_SD, input, 6 each, source registers of the instruction being decoded.
REQ-008 SHALL have port WB_READY_SM, input, 1, writeback accepts the X2 result this cycle.
REQ-009 SHALL have port FLUSH_SM, input, 1, squash all in-flight multiplies.
REQ-010 SHALL have port DEC2X0_POP_SX0, output, 1, pop the decode FIFO.
REQ-011 SHALL have port STAGE_VALID_SX, output, NB_STAGES, per-stage valid; bit 0 is X0.
REQ-012 SHALL have port STAGE_ADV_SX, output, NB_STAGES, per-stage advance enable driven to the datapath registers.
REQ-013 SHALL have port X2_RD_SX2, output, 6, destination of the retiring op.
REQ-014 SHALL have port X2_CMD_SX2, output, 2, command of the retiring op.
REQ-015 SHALL have port RETIRE_SX2, output, 1, result handed to writeback this cycle.
REQ-016 SHALL have port MULT_HAZARD_SD, output, 1, a source register matches a pending destination.
REQ-017 SHALL have port MULT_BUSY_SX, output, 1, any stage valid.

Function
REQ-018 SHALL assert RETIRE_SX2 = valid[X2] & WB_READY_SM.
REQ-019 SHALL compute adv[last] = valid[last] & WB_READY_SM; adv[i] = valid[i] & (~valid[i+1] | adv[i+1]).
REQ-020 SHALL compute DEC2X0_POP_SX0 = ~DEC2X0_EMPTY_SD & (~valid[0] | adv[0]) & ~FLUSH_SM.
REQ-021 SHALL on adv[i] copy the valid, rd and cmd of stage i into stage i+1; a stage that is not refilled and whose content advances SHALL clear its valid.
REQ-022 SHALL load stage X0 from MULT_CMD_SD and RADR_SD on the pop; latency is NB_STAGES cycles from pop to RETIRE_SX2 when unstalled.
REQ-023 SHALL sustain 1 op/cycle throughput with WB_READY_SM held high.
REQ-024 SHALL hold all stages unchanged (no bubble collapse past a stalled X2) while WB_READY_SM is low, except that a bubble upstream SHALL still be filled.
REQ-025 SHALL assert MULT_HAZARD_SD when RADR1_SD or RADR2_SD is nonzero and equals the rd of any valid stage not retiring this cycle.
REQ-026 SHALL clear all valids on the cycle after FLUSH_SM; FLUSH_SM has priority over pop and retire, and RETIRE_SX2 SHALL be forced low during flush.
REQ-027 SHALL never pop while DEC2X0_EMPTY_SD is high, and never overwrite a valid non-advancing stage.

Reset
REQ-028 SHALL asynchronously clear all valids, rd and cmd to 0 on reset_n low; all outputs read 0 during reset.
REQ-029 SHALL discard in-flight ops on reset mid-operation, with no retire on the first cycle after release.

Configuration
REQ-030 SHALL compile, under macro MULT_PERF_CNT_EN, two 32-bit wrapping outputs PERF_ISSUE_SX (pops) and PERF_STALL_SX (cycles with valid[X2] & ~WB_READY_SM), reset to 0.
REQ-031 SHALL, without MULT_PERF_CNT_EN, omit those ports and registers entirely.

Structure
REQ-032 SHALL take mult_cmd_t (2-bit enum) and NB_STAGES_DEF from the shared package mult_pkg.
REQ-033 SHALL instantiate one sub-module, mult_stage_reg (valid/rd/cmd register with load, advance and flush), NB_STAGES times.

Verification
REQ-034 Back-to-back: 4 pops (rd 1,2,3,4), WB_READY_SM=1 -> RETIRE_SX2 at cycles 3..6 with X2_RD_SX2 1,2,3,4.
REQ-035 Backpressure: 3 ops in flight, WB_READY_SM=0 for 5 cycles -> DEC2X0_POP_SX0=0, stages hold; PERF_STALL_SX=5 when MULT_PERF_CNT_EN.
REQ-036 Hazard: rd=5 in X1, RADR1_SD=5 -> MULT_HAZARD_SD=1; rd=0 with RADR1_SD=0 -> 0.
REQ-037 Flush with 3 valid and a pending pop -> no pop, RETIRE_SX2=0, all valids 0 next cycle.
REQ-038 reset_n low with X2 valid -> all outputs 0 immediately; no retire after release.
REQ-039 Bubble: single op, DEC2X0_EMPTY_SD=1 thereafter -> MULT_BUSY_SX high for exactly 3 cycles.
